// File: rtl/ptmch_match_nch.sv
// rtl/ptmch_match_nch.sv - N-channel SPI-flash opcode/address-window trigger and hit counter
module ptmch_match_nch #(
    parameter int NCH     = 5,
    parameter int ADDR_W  = 24,
    parameter int PLS_LEN = 4
) (
    input  logic              CLK100M,
    input  logic              RESET_N,
    input  logic              FRM_VALID,
    input  logic [7:0]        FRM_OPCODE,
    input  logic [ADDR_W-1:0] FRM_ADDR,
    output logic [NCH-1:0]    TRG_PLS,
    input  logic [15:0]       REG_ADDRESS,
    input  logic              REG_CS,
    input  logic              REG_READ,
    input  logic              REG_WRITE,
    input  logic [31:0]       REG_WRITEDATA,
    output logic [31:0]       REG_READDATA,
    output logic              REG_WAITREQUEST
);

    localparam logic [31:0] ID_VAL    = {16'h504D, 8'd0, 8'(NCH)};
    localparam logic [13:0] WORD_ID   = 14'h100;
    localparam logic [13:0] WORD_CLR  = 14'h101;
    localparam logic [13:0] WORD_HITS = 14'h102;

    logic [NCH-1:0]             en, sat, hits, hit, cnt_clr, ch_wr;
    logic [NCH-1:0][7:0]        opc, timer;
    logic [NCH-1:0][ADDR_W-1:0] low, high;
    logic [NCH-1:0][31:0]       count;
    logic [NCH-1:0]             hits_clr;
    logic [31:0]                rd_q, rd_mux;
    logic                       rd_done, wr, rd, rw, ch_sel, clr_all;
    logic [13:0]                word;
    logic [5:0]                 ch_idx;
    logic [1:0]                 ch_reg;
    logic                       unused_ok;

    assign unused_ok = &{1'b0, REG_ADDRESS[1:0], REG_WRITEDATA};

    assign wr     = REG_CS & REG_WRITE;
    assign rd     = REG_CS & REG_READ & ~REG_WRITE;
    assign rw     = REG_CS & REG_READ & REG_WRITE;
    assign word   = REG_ADDRESS[15:2];
    assign ch_idx = REG_ADDRESS[9:4];
    assign ch_reg = REG_ADDRESS[3:2];
    assign ch_sel = (REG_ADDRESS[15:10] == 6'd0) && ({26'd0, ch_idx} < 32'(NCH));
    assign clr_all  = wr && (word == WORD_CLR) && REG_WRITEDATA[0];
    assign hits_clr = (wr && (word == WORD_HITS)) ? REG_WRITEDATA[NCH-1:0] : '0;

    // Compare against the config as it stands before any write landing this cycle.
    always_comb begin
        hit     = '0;
        cnt_clr = '0;
        ch_wr   = '0;
        TRG_PLS = '0;
        for (int c = 0; c < NCH; c++) begin
            hit[c]     = FRM_VALID && en[c] && (FRM_OPCODE == opc[c]) &&
                         (FRM_ADDR >= low[c]) && (FRM_ADDR <= high[c]);
            ch_wr[c]   = wr && ch_sel && (ch_idx == 6'(c));
            cnt_clr[c] = clr_all || (ch_wr[c] && (ch_reg == 2'd3));
            TRG_PLS[c] = (timer[c] != 8'd0);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (ch_sel) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_idx == 6'(c)) begin
                    case (ch_reg)
                        2'd0:    rd_mux = {16'd0, opc[c], 6'd0, sat[c], en[c]};
                        2'd1:    rd_mux = 32'(low[c]);
                        2'd2:    rd_mux = 32'(high[c]);
                        default: rd_mux = count[c];
                    endcase
                end
            end
        end else if (word == WORD_ID) begin
            rd_mux = ID_VAL;
        end else if (word == WORD_HITS) begin
            rd_mux = 32'(hits);
        end
    end

    always_ff @(posedge CLK100M) begin
        if (!RESET_N) begin
            en      <= '0;
            sat     <= '0;
            opc     <= '0;
            low     <= '0;
            high    <= '1;
            count   <= '0;
            timer   <= '0;
            hits    <= '0;
            rd_q    <= '0;
            rd_done <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cnt_clr[c])
                    count[c] <= '0;
                else if (hit[c] && !(sat[c] && (count[c] == 32'hFFFF_FFFF)))
                    count[c] <= count[c] + 32'd1;
                // Reloading on every hit stretches an active pulse without a gap.
                if (hit[c])
                    timer[c] <= 8'(PLS_LEN);
                else if (timer[c] != 8'd0)
                    timer[c] <= timer[c] - 8'd1;
                if (ch_wr[c]) begin
                    case (ch_reg)
                        2'd0: begin
                            en[c]  <= REG_WRITEDATA[0];
                            sat[c] <= REG_WRITEDATA[1];
                            opc[c] <= REG_WRITEDATA[15:8];
                        end
                        2'd1:    low[c]  <= REG_WRITEDATA[ADDR_W-1:0];
                        2'd2:    high[c] <= REG_WRITEDATA[ADDR_W-1:0];
                        default: ;
                    endcase
                end
            end
            hits    <= (hits & ~hits_clr) | hit;
            rd_done <= rd & ~rd_done;
            if (rd & ~rd_done)
                rd_q <= rd_mux;
            else if (rw)
                rd_q <= '0;
        end
    end

    assign REG_WAITREQUEST = rd & ~rd_done;
    assign REG_READDATA    = rw ? 32'd0 : rd_q;

endmodule

// File: tb/tb_ptmch_match_nch.sv
// tb/tb_ptmch_match_nch.sv - directed and randomized checks of ptmch_match_nch against a register-map model
module tb_ptmch_match_nch;

    localparam int NCH     = 5;
    localparam int ADDR_W  = 24;
    localparam int PLS_LEN = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              frm_valid;
    logic [7:0]        frm_opcode;
    logic [ADDR_W-1:0] frm_addr;
    logic [NCH-1:0]    trg_pls;
    logic [15:0]       reg_address;
    logic              reg_cs, reg_read, reg_write;
    logic [31:0]       reg_writedata, reg_readdata;
    logic              reg_waitrequest;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    logic [NCH-1:0]    m_en, m_sat, m_hits;
    logic [7:0]        m_opc  [NCH];
    logic [ADDR_W-1:0] m_low  [NCH];
    logic [ADDR_W-1:0] m_high [NCH];
    logic [31:0]       m_cnt  [NCH];
    int                last_hit [NCH];

    always #5 clk = ~clk;

    ptmch_match_nch #(.NCH(NCH), .ADDR_W(ADDR_W), .PLS_LEN(PLS_LEN)) dut (
        .CLK100M(clk), .RESET_N(resetn),
        .FRM_VALID(frm_valid), .FRM_OPCODE(frm_opcode), .FRM_ADDR(frm_addr),
        .TRG_PLS(trg_pls),
        .REG_ADDRESS(reg_address), .REG_CS(reg_cs), .REG_READ(reg_read),
        .REG_WRITE(reg_write), .REG_WRITEDATA(reg_writedata),
        .REG_READDATA(reg_readdata), .REG_WAITREQUEST(reg_waitrequest)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_sat = '0; m_hits = '0;
        for (int c = 0; c < NCH; c++) begin
            m_opc[c] = '0; m_low[c] = '0; m_high[c] = '1; m_cnt[c] = '0;
            last_hit[c] = -1000;
        end
    endtask

    function automatic logic [31:0] mread(input logic [15:0] a);
        int w, c, off;
        w = int'(a) & 32'hFFFC;
        if (w == 32'h400) return 32'h504D0005;
        if (w == 32'h408) return 32'(m_hits);
        if (w >= 32'h400) return 32'd0;
        c = w / 16;
        off = (w % 16) / 4;
        if (c >= NCH) return 32'd0;
        case (off)
            0:       return {16'd0, m_opc[c], 6'd0, m_sat[c], m_en[c]};
            1:       return 32'(m_low[c]);
            2:       return 32'(m_high[c]);
            default: return m_cnt[c];
        endcase
    endfunction

    // One clock: model the edge from the inputs now applied, then check pulses after it.
    task automatic step();
        logic [NCH-1:0] hm, clrm, hclr, pls;
        int w, c, off;
        hm = '0; clrm = '0; hclr = '0; c = 0; off = 0;
        if (!resetn) begin
            model_reset();
        end else begin
            for (int i = 0; i < NCH; i++)
                hm[i] = frm_valid && m_en[i] && (frm_opcode == m_opc[i]) &&
                        (frm_addr >= m_low[i]) && (frm_addr <= m_high[i]);
            w = int'(reg_address) & 32'hFFFC;
            c = w / 16;
            off = (w % 16) / 4;
            if (reg_cs && reg_write) begin
                if (w == 32'h404 && reg_writedata[0]) clrm = '1;
                if (w == 32'h408) hclr = reg_writedata[NCH-1:0];
                if (w < 32'h400 && c < NCH && off == 3) clrm[c] = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clrm[i]) m_cnt[i] = 0;
                else if (hm[i] && !(m_sat[i] && m_cnt[i] == 32'hFFFF_FFFF)) m_cnt[i] = m_cnt[i] + 1;
                if (hm[i]) last_hit[i] = cycle + 1;
            end
            m_hits = (m_hits & ~hclr) | hm;
            if (reg_cs && reg_write && w < 32'h400 && c < NCH) begin
                case (off)
                    0: begin m_en[c] = reg_writedata[0]; m_sat[c] = reg_writedata[1];
                             m_opc[c] = reg_writedata[15:8]; end
                    1: m_low[c]  = reg_writedata[ADDR_W-1:0];
                    2: m_high[c] = reg_writedata[ADDR_W-1:0];
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
            pls[i] = (cycle >= last_hit[i]) && (cycle - last_hit[i] < PLS_LEN);
        chk(32'(trg_pls), 32'(pls), $sformatf("trg_pls cyc%0d", cycle));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reg_wr(input logic [15:0] a, input logic [31:0] d);
        reg_address = a; reg_writedata = d; reg_cs = 1'b1; reg_write = 1'b1;
        #1;
        chk(32'(reg_waitrequest), 32'd0, "write wait");
        step();
        reg_cs = 1'b0; reg_write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        logic [31:0] exp;
        exp = mread(a);
        reg_address = a; reg_cs = 1'b1; reg_read = 1'b1;
        #1;
        chk(32'(reg_waitrequest), 32'd1, {tag, " wait1"});
        step();
        chk(32'(reg_waitrequest), 32'd0, {tag, " wait2"});
        chk(reg_readdata, exp, tag);
        step();
        reg_cs = 1'b0; reg_read = 1'b0;
        #1;
        chk(reg_readdata, exp, {tag, " hold"});
    endtask

    task automatic frame(input logic [7:0] o, input logic [ADDR_W-1:0] a);
        frm_valid = 1'b1; frm_opcode = o; frm_addr = a;
        step();
        frm_valid = 1'b0;
    endtask

    task automatic force_cnt(input int c, input logic [31:0] v);
        logic [NCH-1:0][31:0] fv;
        m_cnt[c] = v;
        for (int i = 0; i < NCH; i++) fv[i] = m_cnt[i];
        force dut.count = fv;
        #1;
        release dut.count;
    endtask

    initial begin
        resetn = 1'b0; frm_valid = 1'b0; frm_opcode = '0; frm_addr = '0;
        reg_address = '0; reg_cs = 1'b0; reg_read = 1'b0; reg_write = 1'b0; reg_writedata = '0;
        model_reset();
        @(negedge clk);
        idle(3);
        chk(reg_readdata, 32'd0, "reset readdata");
        chk(32'(reg_waitrequest), 32'd0, "reset wait");
        resetn = 1'b1;
        idle(1);

        do_read(16'h400, "id");
        chk(reg_readdata, 32'h504D0005, "id const");
        do_read(16'h004, "ch0 low rst");
        do_read(16'h008, "ch0 high rst");
        chk(reg_readdata, 32'h00FFFFFF, "high const");
        do_read(16'h050, "unmapped ch5");
        do_read(16'h40C, "unmapped 40c");

        reg_wr(16'h000, 32'h0000_0201);
        reg_wr(16'h004, 32'h0000_1000);
        reg_wr(16'h008, 32'h0000_1FFF);
        frame(8'h02, 24'h000FFF); idle(6);
        frame(8'h02, 24'h001000); idle(6);
        frame(8'h02, 24'h001FFF); idle(6);
        frame(8'h02, 24'h002000); idle(6);
        do_read(16'h00C, "ch0 count window");
        chk(reg_readdata, 32'd2, "ch0 count const");

        reg_wr(16'h010, 32'h0000_0301);
        reg_wr(16'h014, 32'h0000_0100);
        reg_wr(16'h018, 32'h0000_01FF);
        reg_wr(16'h020, 32'h0000_0301);
        reg_wr(16'h024, 32'h0000_0180);
        reg_wr(16'h028, 32'h0000_02FF);
        reg_wr(16'h408, 32'hFFFF_FFFF);
        frame(8'h03, 24'h0001A0); idle(5);
        do_read(16'h408, "hits both");
        chk(reg_readdata, 32'h06, "hits const");
        reg_wr(16'h408, 32'h0000_0002);
        do_read(16'h408, "hits after clr");

        frame(8'h02, 24'h001234); idle(1);
        frame(8'h02, 24'h001235); idle(7);
        do_read(16'h00C, "ch0 count stretch");

        reg_wr(16'h000, 32'h0000_0203);
        force_cnt(0, 32'hFFFF_FFFF);
        frame(8'h02, 24'h001800); idle(4);
        do_read(16'h00C, "ch0 sat");
        reg_wr(16'h000, 32'h0000_0201);
        force_cnt(0, 32'hFFFF_FFFF);
        frame(8'h02, 24'h001800); idle(4);
        do_read(16'h00C, "ch0 wrap");

        // Frame and config write in the same cycle: old opcode still matches.
        frm_valid = 1'b1; frm_opcode = 8'h02; frm_addr = 24'h001500;
        reg_wr(16'h000, 32'h0000_0701);
        frm_valid = 1'b0;
        frame(8'h02, 24'h001500); idle(5);
        do_read(16'h00C, "cfg race count");
        reg_wr(16'h000, 32'h0000_0201);

        frm_valid = 1'b1; frm_opcode = 8'h02; frm_addr = 24'h001100;
        reg_wr(16'h404, 32'h0000_0001);
        frm_valid = 1'b0;
        idle(4);
        do_read(16'h00C, "hit vs clr count");
        frm_valid = 1'b1; frm_opcode = 8'h02; frm_addr = 24'h001100;
        reg_wr(16'h408, 32'h0000_001F);
        frm_valid = 1'b0;
        idle(4);
        do_read(16'h408, "hit vs hits clr");
        frm_valid = 1'b1; frm_opcode = 8'h02; frm_addr = 24'h001100;
        reg_wr(16'h00C, 32'h0000_0000);
        frm_valid = 1'b0;
        idle(4);
        do_read(16'h00C, "hit vs count wr");

        reg_address = 16'h020; reg_writedata = 32'h0000_0501;
        reg_cs = 1'b1; reg_read = 1'b1; reg_write = 1'b1;
        #1;
        chk(32'(reg_waitrequest), 32'd0, "rw wait");
        chk(reg_readdata, 32'd0, "rw data");
        step();
        reg_cs = 1'b0; reg_read = 1'b0; reg_write = 1'b0;
        do_read(16'h020, "rw wrote ctrl");

        reg_wr(16'h030, 32'h0000_0501);
        reg_wr(16'h034, 32'h0000_0500);
        reg_wr(16'h038, 32'h0000_05FF);
        reg_wr(16'h040, 32'h0000_0501);
        reg_wr(16'h044, 32'h0000_0700);
        reg_wr(16'h048, 32'h0000_0600);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ops [4];
            ops[0] = 8'h02; ops[1] = 8'h03; ops[2] = 8'h05; ops[3] = 8'($urandom);
            frm_valid  = ($urandom % 2) == 0;
            frm_opcode = ops[$urandom % 4];
            frm_addr   = 24'($urandom_range(0, 32'h2100));
            if (($urandom % 10) == 0) begin
                reg_cs = 1'b1; reg_write = 1'b1;
                reg_address   = (($urandom % 2) == 0) ? 16'h404 : 16'h408;
                reg_writedata = $urandom;
            end
            step();
            reg_cs = 1'b0; reg_write = 1'b0;
        end
        frm_valid = 1'b0;
        idle(5);
        for (int c = 0; c < NCH; c++) do_read(16'(c * 16 + 12), $sformatf("rand count ch%0d", c));
        do_read(16'h408, "rand hits");

        reg_wr(16'h000, 32'h0000_0201);
        frame(8'h02, 24'h001800); idle(1);
        resetn = 1'b0;
        step();
        chk(32'(trg_pls), 32'd0, "reset mid pulse");
        resetn = 1'b1;
        idle(1);
        do_read(16'h000, "post rst ctrl");
        do_read(16'h004, "post rst low");
        do_read(16'h008, "post rst high");
        do_read(16'h00C, "post rst count");
        do_read(16'h408, "post rst hits");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
